mem_arbiter: RTL
================

# mem_arbiter

Two-port-to-one memory arbiter for the pipelined MIPS core. It shares one single-ported, variable-latency memory between the fetch stage (I-side) and the memory stage (D-side). Each transfer is sequenced through a small FSM, with a request/ready handshake on each side. The pipeline derives its fetch and memory-stage stalls from `req & ~ready` on each side.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive D-wins over a pending I-request before I is forced to win; legal range 1..15.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `i_req`  in  1  fetch request; held until `i_ready`.
- `i_addr`  in  32  fetch address; stable while `i_req`.
- `i_rdata`  out  32  fetched word; valid when `i_ready`, held until next I completion.
- `i_ready`  out  1  one-cycle completion pulse for I-side.
- `d_req`  in  1  load/store request; held until `d_ready`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data address.
- `d_wdata`  in  32  store data.
- `d_rdata`  out  32  load data; valid when `d_ready` after a load; unchanged by stores.
- `d_ready`  out  1  one-cycle completion pulse for D-side.
- `m_req`  out  1  memory request, held until `m_ready`.
- `m_we`  out  1  memory write enable.
- `m_addr`  out  32  memory address.
- `m_wdata`  out  32  memory write data.
- `m_rdata`  in  32  memory read data; valid in the `m_ready` cycle.
- `m_ready`  in  1  memory completion; sampled only while `m_req`=1.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any request is pending, pick a winner, register `m_addr`/`m_we`/`m_wdata` from the winner (I-side: `m_we`=0, `m_wdata`=0), set `m_req`=1, go to BUSY. Otherwise stay.
- Arbitration: D wins by default. I wins if only I requests, or if both request and `starve_cnt` == `STARVE_LIMIT`.
- `starve_cnt`: increments when D wins while `i_req`=1, clears when I wins, saturates at `STARVE_LIMIT`.
- BUSY: `m_*` outputs are stable. On `m_ready`=1, capture `m_rdata` into the winner's rdata register (loads/fetches only), drop `m_req`, go to RESP.
- RESP: pulse the winner's ready for exactly one cycle, do not arbitrate, go to IDLE. This keeps a still-asserted req from being re-issued.
- Requester dropping req mid-transaction (e.g. fetch flush): the transfer completes, the ready pulse is still issued, and the requester ignores it.
- `i_ready` and `d_ready` are never high together. `m_req` is never high in IDLE or RESP.
- Reset: state=IDLE, `starve_cnt`=0. All outputs (`m_req`, `m_we`, `m_addr`, `m_wdata`, `i_rdata`, `d_rdata`, `i_ready`, `d_ready`) are 0.
- Reset mid-transaction: `m_req` drops asynchronously and no ready pulse is issued. Memory must tolerate an abandoned request.

## Timing
- Request seen at cycle 0 (IDLE) → `m_req`=1 at cycle 1.
- `m_ready` at cycle k≥1 → ready pulse plus data at cycle k+1 → IDLE at k+2.
- Minimum latency from req to ready is 2 cycles with zero-wait memory (`m_ready` in cycle 1).
- Maximum throughput is one transfer per 3 cycles.
- Requests arriving during BUSY/RESP wait and are arbitrated in the next IDLE cycle.
- Worst-case I-side wait under continuous D traffic: `STARVE_LIMIT` D transfers, then the I transfer.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum `arb_state_t` {IDLE, BUSY, RESP};
  - grant enum `arb_gnt_t` {GNT_I, GNT_D}.
- Single module, no sub-modules. Starvation counter and pick logic stay inline; width is 4 bits (max `STARVE_LIMIT` 15).

## Test plan
- Lone fetch, zero-wait memory: `i_req`=1, `i_addr`=0x00400000, `m_rdata`=0x8C080004 → `m_req` at cycle 1, `i_ready` plus `i_rdata`=0x8C080004 at cycle 2, `m_we`=0.
- Lone store, 3-cycle memory: `d_we`=1, `d_addr`=0x10010008, `d_wdata`=0xDEADBEEF → `m_*` stable for 3 cycles, `d_ready` one cycle after `m_ready`, `d_rdata` unchanged.
- Simultaneous requests, `STARVE_LIMIT`=4, `d_req` held continuously with `i_req`=1 → grant order D,D,D,D,I,D,D,D,D,I.
- Fetch flush: `i_req` dropped at cycle 2 during BUSY → transfer finishes, `i_ready` pulses once, and no second `m_req` is issued for I.
- Reset asserted during BUSY → `m_req`=0 immediately, no ready pulse, all outputs 0. After release, a new D load completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter.
// Holds the FSM state encoding, the grant encoding and the starvation counter width.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;

  typedef enum logic {GNT_I, GNT_D} arb_gnt_t;

  localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port-to-one arbiter sharing a variable-latency memory between fetch (I) and data (D).
// Data wins by default; a fetch is forced through after STARVE_LIMIT consecutive bypasses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready
);

  localparam logic [STARVE_W-1:0] Limit = STARVE_W'(STARVE_LIMIT);

  arb_state_t          state;
  arb_gnt_t            gnt;
  logic [STARVE_W-1:0] starve_cnt;
  logic                i_wins;

  assign i_wins = i_req & (~d_req | (starve_cnt == Limit));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      gnt        <= GNT_D;
      starve_cnt <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          if (i_req || d_req) begin
            m_req <= 1'b1;
            state <= BUSY;
            if (i_wins) begin
              gnt        <= GNT_I;
              m_we       <= 1'b0;
              m_addr     <= i_addr;
              m_wdata    <= '0;
              starve_cnt <= '0;
            end else begin
              gnt     <= GNT_D;
              m_we    <= d_we;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              // Only count bypasses of a waiting fetch, saturating at the limit.
              if (i_req && (starve_cnt != Limit)) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
              end
            end
          end
        end
        BUSY: begin
          if (m_ready) begin
            m_req <= 1'b0;
            state <= RESP;
            if (gnt == GNT_I) begin
              i_rdata <= m_rdata;
              i_ready <= 1'b1;
            end else begin
              if (!m_we) begin
                d_rdata <= m_rdata;
              end
              d_ready <= 1'b1;
            end
          end
        end
        RESP: begin
          // No arbitration here, so a requester still holding req is not re-served.
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          m_req   <= 1'b0;
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
